// File: rtl/prog_rom.sv
// prog_rom: program ROM with 1-cycle fetch; define PROG_ROM_LOAD_EN to add the
// streaming loader (IDLE/LOAD FSM) that writes the array and blocks fetches while busy.
module prog_rom #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 15,
   parameter int DEPTH  = 32768
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_valid,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              busy,
   output logic              load_overflow
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic              we;
   logic [IW-1:0]     wa;
   logic [DATA_W-1:0] wd;
   logic              take;
   assign take = fetch_req && !busy;
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         fetch_valid <= 1'b0;
         fetch_data  <= '0;
      end else begin
         fetch_valid <= take;
         if (take)
            fetch_data <= ({1'b0, fetch_addr} < DEPTH_X) ? mem[fetch_addr[IW-1:0]] : '0;
      end
   end
   always_ff @(posedge clock)
      if (we) mem[wa] <= wd;
`ifdef PROG_ROM_LOAD_EN
   typedef enum logic {IDLE, LOAD} state_t;
   localparam logic [IW-1:0] LAST = IW'(DEPTH-1);
   state_t        state;
   logic [IW-1:0] ptr;
   logic          wrap;
   assign wrap = ptr >= LAST;
   assign we   = reset_n && state == LOAD && load_valid;
   assign wa   = ptr;
   assign wd   = load_data;
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         ptr           <= '0;
         busy          <= 1'b0;
         load_overflow <= 1'b0;
      end else if (state == IDLE) begin
         if (load_start) begin
            state         <= LOAD;
            ptr           <= load_base[IW-1:0];
            busy          <= 1'b1;
            load_overflow <= 1'b0;
         end
      end else if (load_valid) begin
         ptr <= wrap ? '0 : ptr + 1'b1;
         if (wrap) load_overflow <= 1'b1;
         if (load_last) begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end
`else
   // Read-only build: array stays at its configuration value, loader inputs are sunk.
   logic unused_load;
   assign unused_load   = ^{load_start, load_base, load_valid, load_data, load_last};
   assign we            = 1'b0;
   assign wa            = '0;
   assign wd            = '0;
   assign busy          = 1'b0;
   assign load_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_prog_rom.sv
// tb_prog_rom: directed checks of prog_rom; u0 uses default sizing, u1 has DEPTH=8
// for the wrap and out-of-range cases. Loader cases run only with PROG_ROM_LOAD_EN.
module tb_prog_rom;
   logic        clock = 1'b0;
   logic        reset_n, fetch_req, load_start, load_valid, load_last;
   logic [14:0] fetch_addr, load_base;
   logic [15:0] load_data;
   logic [15:0] fd0, fd1;
   logic        fv0, fv1, busy0, busy1, ovf0, ovf1;
   int          checks = 0;
   int          errors = 0;

   always #5 clock = ~clock;

   prog_rom u0 (
      .clock(clock), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_data(fd0), .fetch_valid(fv0), .load_start(load_start), .load_base(load_base),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .busy(busy0), .load_overflow(ovf0)
   );

   prog_rom #(.DATA_W(16), .ADDR_W(4), .DEPTH(8)) u1 (
      .clock(clock), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr[3:0]),
      .fetch_data(fd1), .fetch_valid(fv1), .load_start(load_start), .load_base(load_base[3:0]),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .busy(busy1), .load_overflow(ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic fetch0(input logic [14:0] a, input logic [15:0] exp, input string tag);
      fetch_req  = 1'b1;
      fetch_addr = a;
      cyc();
      chk({tag, "_v"}, 32'(fv0), 32'd1);
      chk({tag, "_d"}, 32'(fd0), 32'(exp));
   endtask

   task automatic fetch1(input logic [14:0] a, input logic [15:0] exp, input string tag);
      fetch_req  = 1'b1;
      fetch_addr = a;
      cyc();
      chk({tag, "_v"}, 32'(fv1), 32'd1);
      chk({tag, "_d"}, 32'(fd1), 32'(exp));
   endtask

   task automatic word(input logic [15:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      cyc();
   endtask

   initial begin
      reset_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
      load_base = '0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      cyc(); cyc();
      chk("rst_fv", 32'(fv0), 32'd0);
      chk("rst_fd", 32'(fd0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_ovf", 32'(ovf0), 32'd0);
      reset_n = 1'b1;
      fetch0(15'd5, 16'h0000, "zero5");
      fetch_req = 1'b0;
      cyc();
      chk("idle_fv", 32'(fv0), 32'd0);
      chk("idle_hold", 32'(fd0), 32'd0);
`ifdef PROG_ROM_LOAD_EN
      // load_start together with a fetch: the fetch is still served
      load_start = 1'b1; load_base = 15'd2; fetch_req = 1'b1; fetch_addr = 15'd5;
      cyc();
      chk("start_busy", 32'(busy0), 32'd1);
      chk("start_fv", 32'(fv0), 32'd1);
      load_start = 1'b0;
      word(16'h0010, 1'b0);
      chk("ld1_busy", 32'(busy0), 32'd1);
      chk("ld1_fv", 32'(fv0), 32'd0);
      word(16'hEC10, 1'b0);
      chk("ld2_busy", 32'(busy0), 32'd1);
      word(16'h0011, 1'b1);
      chk("ld3_busy", 32'(busy0), 32'd0);
      chk("ld3_fv", 32'(fv0), 32'd0);
      load_valid = 1'b0; load_last = 1'b0;
      fetch0(15'd2, 16'h0010, "rd2");
      fetch0(15'd3, 16'hEC10, "rd3");
      fetch0(15'd4, 16'h0011, "rd4");
      // load_valid while idle must not write
      fetch_req = 1'b0;
      word(16'hFFFF, 1'b0);
      chk("idlev_busy", 32'(busy0), 32'd0);
      load_valid = 1'b0;
      fetch0(15'd5, 16'h0000, "idlev5");
      fetch0(15'd2, 16'h0010, "idlev2");
      // wrap on the DEPTH=8 instance; second load_start inside LOAD is ignored
      fetch_req = 1'b0;
      load_start = 1'b1; load_base = 15'd6;
      cyc();
      chk("w_ovf0", 32'(ovf1), 32'd0);
      load_base = 15'd0;
      word(16'h1111, 1'b0);
      load_start = 1'b0;
      chk("w1_ovf", 32'(ovf1), 32'd0);
      word(16'h2222, 1'b0);
      chk("w2_ovf", 32'(ovf1), 32'd1);
      word(16'h3333, 1'b0);
      word(16'h4444, 1'b1);
      chk("w4_busy", 32'(busy1), 32'd0);
      chk("w4_ovf", 32'(ovf1), 32'd1);
      load_valid = 1'b0; load_last = 1'b0;
      fetch1(15'd6, 16'h1111, "w6");
      fetch1(15'd7, 16'h2222, "w7");
      fetch1(15'd0, 16'h3333, "w0");
      fetch1(15'd1, 16'h4444, "w1");
      fetch1(15'd2, 16'h0010, "w2keep");
      fetch1(15'd9, 16'h0000, "oor9");
      chk("ovf_sticky", 32'(ovf1), 32'd1);
      fetch0(15'd7, 16'h2222, "u0_7");
      fetch_req = 1'b0;
      load_start = 1'b1; load_base = 15'd3;
      cyc();
      load_start = 1'b0;
      chk("ovf_clr", 32'(ovf1), 32'd0);
      word(16'h5555, 1'b1);
      load_valid = 1'b0; load_last = 1'b0;
      fetch1(15'd3, 16'h5555, "w3");
      // reset in the middle of a load aborts it
      fetch_req = 1'b0;
      load_start = 1'b1; load_base = 15'd10;
      cyc();
      load_start = 1'b0;
      word(16'hAAAA, 1'b0);
      word(16'hBBBB, 1'b0);
      reset_n = 1'b0;
      word(16'hCCCC, 1'b0);
      chk("ab_busy", 32'(busy0), 32'd0);
      chk("ab_fd", 32'(fd0), 32'd0);
      reset_n = 1'b1;
      word(16'hDDDD, 1'b0);
      chk("ab_idle", 32'(busy0), 32'd0);
      load_valid = 1'b0;
      fetch0(15'd10, 16'hAAAA, "ab10");
      fetch0(15'd11, 16'hBBBB, "ab11");
      fetch0(15'd12, 16'h0000, "ab12");
`else
      // read-only build: a full load sequence changes nothing
      fetch_req = 1'b0;
      load_start = 1'b1; load_base = 15'd2;
      cyc();
      chk("ro_busy0", 32'(busy0), 32'd0);
      load_start = 1'b0;
      word(16'h0010, 1'b0);
      chk("ro_busy1", 32'(busy0), 32'd0);
      word(16'hEC10, 1'b0);
      chk("ro_busy2", 32'(busy0), 32'd0);
      word(16'h0011, 1'b1);
      chk("ro_busy3", 32'(busy0), 32'd0);
      chk("ro_ovf", 32'(ovf0), 32'd0);
      load_valid = 1'b0; load_last = 1'b0;
      fetch0(15'd2, 16'h0000, "ro2");
      fetch0(15'd3, 16'h0000, "ro3");
      fetch0(15'd4, 16'h0000, "ro4");
      fetch1(15'd9, 16'h0000, "ro_oor9");
      chk("ro_busy8", 32'(busy1), 32'd0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
